fetch_seq: RTL
==============

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_VEC, default 8'h80: PC value loaded after reset.
REQ-002 Parameter HALT_OP, default 8'hFF: opcode that stops sequencing.
REQ-003 Parameter FETCH_TMO, default 15: maximum wait cycles for instr_ack before fault.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 run  input  1  enables sequencing out of IDLE and continuation after UPDATE.
REQ-007 instr_req  output  1  instruction memory read request.
REQ-008 instr_ack  input  1  instruction memory data valid.
REQ-009 instr_data  input  8  fetched instruction.
REQ-010 ex_done  input  1  control unit finished executing current instruction.
REQ-011 br_taken  input  1  branch decision, valid with ex_done.
REQ-012 br_target  input  8  branch target, valid with ex_done.
REQ-013 pc_inc  output  1  one-cycle PC increment strobe.
REQ-014 pc_load  output  1  one-cycle PC load strobe.
REQ-015 pc_target  output  8  value for PC on pc_load.
REQ-016 ir  output  8  instruction register.
REQ-017 decode_valid  output  1  ir valid for decode, one cycle.
REQ-018 halt  output  1  HALT_OP reached.
REQ-019 fault  output  1  fetch timeout.
REQ-020 retired  output  8  count of completed instructions.

Function
REQ-021 States SHALL be INIT, IDLE, FETCH, DECODE, EXEC, UPDATE, HALT, FAULT.
REQ-022 INIT: pc_load=1, pc_target=RESET_VEC for exactly one cycle, then IDLE.
REQ-023 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-024 FETCH: instr_req=1 every cycle in state; ir<=instr_data on the instr_ack cycle, then DECODE.
REQ-025 FETCH: wait counter increments each cycle without ack; when counter reaches FETCH_TMO with no ack -> FAULT, instr_req drops; counter clears on entering FETCH.
REQ-026 instr_ack outside FETCH SHALL be ignored; ir unchanged.
REQ-027 DECODE: decode_valid=1 for one cycle; ir==HALT_OP -> HALT, else EXEC.
REQ-028 EXEC: wait for ex_done; on ex_done capture br_taken and br_target, -> UPDATE; ex_done in any other state ignored.
REQ-029 UPDATE: one cycle; taken -> pc_load=1, pc_target=captured target; not taken -> pc_inc=1; retired increments.
REQ-030 UPDATE exit: run=1 -> FETCH, run=0 -> IDLE; run deassertion mid-instruction does not abort it.
REQ-031 pc_inc and pc_load SHALL never be asserted in the same cycle.
REQ-032 retired SHALL wrap 8'hFF -> 8'h00; HALT instruction not counted.
REQ-033 HALT and FAULT SHALL be terminal; halt/fault held at 1 until rst.
REQ-034 Fetch-to-PC-update minimum latency: FETCH(ack same cycle)+DECODE+EXEC(ex_done same cycle)+UPDATE = 4 cycles.

Reset
REQ-035 rst=1 at any clock edge, in any state, SHALL force INIT next cycle; ir, retired, wait counter, captured branch = 0; all outputs 0 except the INIT pc_load.
REQ-036 Reset mid-FETCH SHALL drop instr_req the cycle after rst sampled.

Structure
REQ-037 State encoding, RESET_VEC, HALT_OP, FETCH_TMO defaults SHALL live in shared package cpu_pkg.
REQ-038 Single flat module; no sub-modules; counter width 4 bits for FETCH_TMO<=15.

Verification
REQ-039 Reset then run=1, ack immediate, ir=8'h12, ex_done with br_taken=0 -> pc_load/pc_target=8'h80 one cycle after reset, pc_inc in UPDATE, retired=1.
REQ-040 Branch: instr 8'h34, ex_done with br_taken=1, br_target=8'hA0 -> pc_load=1, pc_target=8'hA0, pc_inc=0.
REQ-041 instr_ack withheld 15 cycles -> fault=1, instr_req=0, held until rst.
REQ-042 instr_data=8'hFF -> decode_valid one cycle then halt=1; retired unchanged; run toggling has no effect.
REQ-043 run=0 during EXEC -> instruction completes, UPDATE strobe issued, then IDLE; 256 retired instructions -> retired=8'h00.
REQ-044 rst pulsed during FETCH with instr_req=1 -> next cycle INIT pc_load to 8'h80, ir=0, retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding
// and the default reset vector, halt opcode and fetch timeout.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [7:0] RESET_VEC_DEF = 8'h80;
  localparam logic [7:0] HALT_OP_DEF   = 8'hFF;
  localparam int         FETCH_TMO_DEF = 15;
  localparam int         WAIT_W        = 4;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch/decode/execute sequencer: drives the PC strobes, holds
// the instruction register and counts retired instructions.
module fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [7:0] HALT_OP   = HALT_OP_DEF,
  parameter int         FETCH_TMO = FETCH_TMO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       instr_req,
  input  logic       instr_ack,
  input  logic [7:0] instr_data,
  input  logic       ex_done,
  input  logic       br_taken,
  input  logic [7:0] br_target,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [7:0] ir,
  output logic       decode_valid,
  output logic       halt,
  output logic       fault,
  output logic [7:0] retired
);

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(FETCH_TMO);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [7:0]          r_ir;
  logic [7:0]          r_retired;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic                w_tmo;
  logic                r_br_taken;
  logic [7:0]          r_br_target;

  // A FETCH cycle without ack that brings the count to TMO is the last one,
  // so the request is held for exactly FETCH_TMO cycles before giving up.
  assign w_wait_inc = r_wait + 1'b1;
  assign w_tmo      = (w_wait_inc == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_ir        <= '0;
      r_retired   <= '0;
      r_wait      <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter only runs inside FETCH, so every entry starts from zero.
      r_wait  <= (r_state == ST_FETCH) ? w_wait_inc : '0;
      if (r_state == ST_FETCH && instr_ack)
        r_ir <= instr_data;
      if (r_state == ST_EXEC && ex_done) begin
        r_br_taken  <= br_taken;
        r_br_target <= br_target;
      end
      if (r_state == ST_UPDATE)
        r_retired <= r_retired + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    instr_req    = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    decode_valid = 1'b0;
    halt         = 1'b0;
    fault        = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        pc_load     = 1'b1;
        pc_target   = RESET_VEC;
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ack)  w_state_nxt = ST_DECODE;
        else if (w_tmo) w_state_nxt = ST_FAULT;
      end
      ST_DECODE: begin
        decode_valid = 1'b1;
        w_state_nxt  = (r_ir == HALT_OP) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (ex_done) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        // Taken and not-taken are exclusive, so the two PC strobes never overlap.
        pc_load     = r_br_taken;
        pc_inc      = ~r_br_taken;
        pc_target   = r_br_taken ? r_br_target : 8'h00;
        w_state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:  halt  = 1'b1;
      ST_FAULT: fault = 1'b1;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  assign ir      = r_ir;
  assign retired = r_retired;

endmodule
